// File: rtl/cpu_fetch_pkg.sv
// Shared types and widths for the moxie instruction fetch stage.
package cpu_fetch_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    REDIRECT = 2'd0,
    REQ      = 2'd1,
    PUSH     = 2'd2,
    DRAIN    = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_fetch_align.sv
// Skid word plus residual halfword: turns halfword-aligned fetch streams into
// 32-bit FIFO words.
module cpu_fetch_align
  import cpu_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              arm,
  input  logic              misalign,
  input  logic              capture,
  input  logic [WORD_W-1:0] rdata,
  input  logic              pop,
  output logic [WORD_W-1:0] word,
  output logic              valid
);

  logic [HALF_W-1:0] residual;
  logic              res_valid;
  logic              first_half;

  // The pushed word is formed at capture time, so the residual advances with
  // each accepted bus word while the assembled word waits in the skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word       <= '0;
      valid      <= 1'b0;
      residual   <= '0;
      res_valid  <= 1'b0;
      first_half <= 1'b0;
    end else if (clear) begin
      valid      <= 1'b0;
      res_valid  <= 1'b0;
      first_half <= 1'b0;
    end else begin
      if (arm) begin
        first_half <= misalign;
        res_valid  <= 1'b0;
      end
      if (pop) begin
        valid <= 1'b0;
      end
      if (capture) begin
        if (first_half) begin
          residual   <= rdata[HALF_W-1:0];
          res_valid  <= 1'b1;
          first_half <= 1'b0;
        end else if (res_valid) begin
          word     <= {residual, rdata[WORD_W-1:HALF_W]};
          residual <= rdata[HALF_W-1:0];
          valid    <= 1'b1;
        end else begin
          word  <= rdata;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: Wishbone-classic read master feeding the
// instruction FIFO, with branch redirect and halfword realignment.
module cpu_fetch
  import cpu_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] BOOT_ADDRESS = 32'h0000_1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [WORD_W-1:0] imem_adr_o,
  output logic              imem_cyc_o,
  output logic              imem_stb_o,
  input  logic [WORD_W-1:0] imem_dat_i,
  input  logic              imem_ack_i,
  output logic [WORD_W-1:0] ififo_data_o,
  output logic              ififo_write_en_o,
  input  logic              ififo_full_i,
  output logic              ififo_newpc_o,
  output logic [WORD_W-1:0] ififo_pc_o,
  input  logic              branch_i,
  input  logic [WORD_W-1:0] branch_target_i
);

  localparam logic [WORD_W-1:0] BOOT_WORD = {BOOT_ADDRESS[WORD_W-1:2], 2'b00};

  state_e            state, state_next;
  logic [WORD_W-1:0] fetch_addr, fetch_addr_next;
  logic [WORD_W-1:0] pc, pc_next;
  logic              cyc, cyc_next;
  logic              newpc, newpc_next;
  logic              capture, arm, push;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  // Next state; REDIRECT lasts until its newpc pulse has been shown with no
  // branch overriding it, which also covers the first cycle out of reset.
  always_comb begin
    state_next      = state;
    capture         = 1'b0;
    arm             = 1'b0;
    push            = 1'b0;
    cyc_next        = 1'b0;
    newpc_next      = 1'b0;
    fetch_addr_next = fetch_addr;
    pc_next         = pc;

    case (state)
      REDIRECT: begin
        if (!branch_i && newpc) begin
          state_next = REQ;
          arm        = 1'b1;
        end
      end
      REQ: begin
        if (branch_i) begin
          state_next = imem_ack_i ? REDIRECT : DRAIN;
        end else if (imem_ack_i) begin
          state_next = PUSH;
          capture    = 1'b1;
        end
      end
      PUSH: begin
        if (branch_i) begin
          state_next = REDIRECT;
        end else if (!word_valid) begin
          state_next = REQ;
        end else if (!ififo_full_i) begin
          push       = 1'b1;
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (imem_ack_i) begin
          state_next = REDIRECT;
        end
      end
      default: state_next = REDIRECT;
    endcase

    if (branch_i) begin
      pc_next = branch_target_i;
    end
    if (arm) begin
      fetch_addr_next = {pc[WORD_W-1:2], 2'b00};
    end else if (capture) begin
      fetch_addr_next = fetch_addr + WORD_W'(4);
    end

    cyc_next   = (state_next == REQ) || (state_next == DRAIN);
    newpc_next = (state_next == REDIRECT) &&
                 ((state != REDIRECT) || !newpc || branch_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= REDIRECT;
      fetch_addr <= BOOT_WORD;
      pc         <= BOOT_ADDRESS;
      cyc        <= 1'b0;
      newpc      <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_addr <= fetch_addr_next;
      pc         <= pc_next;
      cyc        <= cyc_next;
      newpc      <= newpc_next;
    end
  end

  cpu_fetch_align u_align (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (branch_i),
    .arm      (arm),
    .misalign (pc[1]),
    .capture  (capture),
    .rdata    (imem_dat_i),
    .pop      (push),
    .word     (word),
    .valid    (word_valid)
  );

  // The push strobe must see this cycle's full flag and branch, so it is
  // the one output decoded directly from inputs.
  assign ififo_write_en_o = push;
  assign ififo_data_o     = word;
  assign imem_adr_o       = fetch_addr;
  assign imem_cyc_o       = cyc;
  assign imem_stb_o       = cyc;
  assign ififo_newpc_o    = newpc;
  assign ififo_pc_o       = pc;

endmodule
